// File: rtl/win3x3_pkg.sv
// Shared defaults and types for the 3x3 window line-buffer block.
package win3x3_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int COL_W      = $clog2(DEF_IMG_W);
    localparam int ROW_W      = $clog2(DEF_IMG_H);

    typedef logic [DEF_DATA_W-1:0] pixel_t;
endpackage

// File: rtl/win3x3_linebuf_ram.sv
// Single-row line buffer: one write port, one combinational read port.
// A read and a write at the same address in one cycle return the old word.
module win3x3_linebuf_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/win3x3_linebuf.sv
// Builds a 3x3 pixel window from a raster stream using two line buffers.
// Optional macro WIN3X3_BORDER_ZERO_EN zero-fills out-of-image taps and marks every window valid.
module win3x3_linebuf
    import win3x3_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pixelEN,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              sof_in,
    output logic [DATA_W-1:0] A00,
    output logic [DATA_W-1:0] A01,
    output logic [DATA_W-1:0] A02,
    output logic [DATA_W-1:0] A10,
    output logic [DATA_W-1:0] A11,
    output logic [DATA_W-1:0] A12,
    output logic [DATA_W-1:0] A20,
    output logic [DATA_W-1:0] A21,
    output logic [DATA_W-1:0] A22,
    output logic              win_valid,
    output logic              sof_out,
    output logic              eol_out
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic              accept;
    logic [CW-1:0]     col, c;
    logic [RW-1:0]     row, r;
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [DATA_W-1:0] nxt_a00, nxt_a01, nxt_a02;
    logic [DATA_W-1:0] nxt_a10, nxt_a11, nxt_a12;
    logic [DATA_W-1:0] nxt_a20, nxt_a21;
    logic              nxt_valid;

    assign accept = en && pixelEN;
    // sof_in on an accepted pixel re-anchors it at (0,0) regardless of the counters
    assign c = sof_in ? '0 : col;
    assign r = sof_in ? '0 : row;

    win3x3_linebuf_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (c),
        .wdata (pix_in),
        .rdata (lb1_rd)
    );

    win3x3_linebuf_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (c),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    always_comb begin
        nxt_a02   = lb0_rd;
        nxt_a12   = lb1_rd;
        nxt_a01   = A02;
        nxt_a11   = A12;
        nxt_a21   = A22;
        nxt_a00   = A01;
        nxt_a10   = A11;
        nxt_a20   = A21;
        nxt_valid = (r >= RW'(2)) && (c >= CW'(2));
`ifdef WIN3X3_BORDER_ZERO_EN
        // Shifted taps inherit the row zeroing already applied when they entered column 2
        if (r < RW'(2)) nxt_a02 = '0;
        if (r < RW'(1)) nxt_a12 = '0;
        if (c < CW'(1)) begin
            nxt_a01 = '0;
            nxt_a11 = '0;
            nxt_a21 = '0;
        end
        if (c < CW'(2)) begin
            nxt_a00 = '0;
            nxt_a10 = '0;
            nxt_a20 = '0;
        end
        nxt_valid = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            A00       <= '0;
            A01       <= '0;
            A02       <= '0;
            A10       <= '0;
            A11       <= '0;
            A12       <= '0;
            A20       <= '0;
            A21       <= '0;
            A22       <= '0;
            win_valid <= 1'b0;
            sof_out   <= 1'b0;
            eol_out   <= 1'b0;
        end else if (accept) begin
            if (c == COL_LAST) begin
                col <= '0;
                row <= (r == ROW_LAST) ? '0 : r + RW'(1);
            end else begin
                col <= c + CW'(1);
                row <= r;
            end
            A00       <= nxt_a00;
            A01       <= nxt_a01;
            A02       <= nxt_a02;
            A10       <= nxt_a10;
            A11       <= nxt_a11;
            A12       <= nxt_a12;
            A20       <= nxt_a20;
            A21       <= nxt_a21;
            A22       <= pix_in;
            win_valid <= nxt_valid;
            sof_out   <= (r == '0) && (c == '0);
            eol_out   <= (c == COL_LAST);
        end
    end
endmodule

// File: doc/win3x3_linebuf.md
Name: win3x3_linebuf

Overview:
Builds the 3x3 pixel window (A00..A22) that feeds the 3x3 median kernel from a raster-order pixel stream, one pixel per en && pixelEN strobe. It holds two full-row line buffers plus a 3x3 register window, and tracks column/row position. It flags when the window is fully inside the image and marks frame and line boundaries for downstream alignment.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
en  in  1  global enable; when low, all state holds
pixelEN  in  1  pixel strobe; pixel accepted on a clk edge when en && pixelEN
pix_in  in  DATA_W  incoming pixel, raster order
sof_in  in  1  qualified with the accept; marks pixel (row 0, col 0)
A00,A01,A02  out  DATA_W each  window row r-2, cols c-2..c
A10,A11,A12  out  DATA_W each  window row r-1, cols c-2..c
A20,A21,A22  out  DATA_W each  window row r, cols c-2..c; A22 is the newest pixel
win_valid  out  1  window updated and fully in-image
sof_out  out  1  window's A22 is pixel (0,0)
eol_out  out  1  window's A22 is at col IMG_W-1

Behaviour:
- Reset (rst high, async): all outputs 0, col=0, row=0. Line-buffer RAM is not reset; contents are don't-care.
- Accept = en && pixelEN. Without an accept, everything holds, including the outputs and the 1-cycle flags.
- On an accept at position (r,c), with c=col, or c=0,r=0 if sof_in:
  - lb1_rd = lb1[c] (row r-1) and lb0_rd = lb0[c] (row r-2), both read combinationally, returning old data.
  - Write lb1[c] <= pix_in and lb0[c] <= lb1_rd.
  - Shift the window left: Ax0<=Ax1, Ax1<=Ax2. Then A22<=pix_in, A12<=lb1_rd, A02<=lb0_rd.
  - win_valid <= (r>=2 && c>=2). sof_out <= (r==0 && c==0). eol_out <= (c==IMG_W-1).
- Latency: outputs are registered and valid from the cycle after the accept edge. The median kernel samples them on its next accept.
- Counters:
  - col increments per accept and wraps IMG_W-1 -> 0 with row++.
  - row wraps IMG_H-1 -> 0 at end of the last line, so the next frame starts without sof_in.
- sof_in on an accept mid-frame forces that pixel to (0,0). Counters resync. Line buffers are not cleared, and win_valid stays low until the new frame's (2,2).
- sof_in without an accept is ignored.
- rst asserted mid-frame: the next accepted pixel is treated as (0,0).
- Flags are level outputs that persist until the next accept, not timed pulses.

Optional Feature:
Macro WIN3X3_BORDER_ZERO_EN.
- Defined: any tap whose row index (r-2 or r-1) or column index (c-2 or c-1) is negative is loaded with 0 instead of stale data. win_valid <= 1 on every accept, giving IMG_W*IMG_H windows per frame.
- Undefined: taps carry whatever the shift and line buffers hold. win_valid follows the r>=2 && c>=2 rule, giving (IMG_W-2)*(IMG_H-2) windows per frame.

Decomposition:
- Package win3x3_pkg: DATA_W/IMG_W/IMG_H defaults, COL_W=$clog2(IMG_W), ROW_W=$clog2(IMG_H), pixel typedef.
- One sub-module win3x3_linebuf_ram: depth IMG_W, width DATA_W, one write and one combinational read port, read-before-write at the same address. Instantiate it twice (lb0, lb1).
- Counters, window registers and flags stay in the top module.

Test Plan:
All scenarios use IMG_W=4, IMG_H=4, pix = row*16+col.
1. Async rst mid-cycle -> all outputs 0 immediately. First accept afterwards gives sof_out=1 and A22=pix_in.
2. Full frame with sof_in at (0,0), continuous accepts -> after pixel (2,2): A00..A02=00,01,02; A10..A12=10,11,12; A20..A22=20,21,22; win_valid=1. Exactly 4 valid windows per frame, the last at (3,3) with A00=11 and A22=33.
3. Same frame with random en/pixelEN gaps (up to 5 idle cycles) -> window sequence identical to scenario 2, and outputs stable during gaps.
4. Two back-to-back frames, sof_in only on the first -> row wraps after (3,3). The second frame yields sof_out on its (0,0) and the same 4 valid windows. eol_out=1 on every c=3 window.
5. sof_in asserted at (1,2) -> counters restart; no win_valid until the new (2,2), whose window equals scenario 2.
6. With WIN3X3_BORDER_ZERO_EN:
   - pixel (0,0) -> A22=00, other taps 0, win_valid=1.
   - pixel (1,1) -> A11=00, A12=01, A21=10, A22=11; A00,A01,A02,A10,A20=0.
   - 16 valid windows per frame.
